// File: rtl/copr_latency_engine_if.sv
// Handshake bundle between the arithmetic reservation station and the latency engine.
// The issue side carries valid/ready plus the operation; the result side carries valid/ready, tag and rd.
interface copr_latency_engine_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
);
    logic             valid_i;
    logic             ready_o;
    logic             ctl_i;
    logic [TAG_W-1:0] tag_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic             valid_o;
    logic             ready_i;
    logic [TAG_W-1:0] tag_o;
    logic [XLEN-1:0]  rd_o;

    modport master (
        output valid_i, ctl_i, tag_i, rs1_i, rs2_i, ready_i,
        input  ready_o, valid_o, tag_o, rd_o
    );

    modport slave (
        input  valid_i, ctl_i, tag_i, rs1_i, rs2_i, ready_i,
        output ready_o, valid_o, tag_o, rd_o
    );
endinterface

// File: rtl/copr_latency_engine.sv
// Dummy-coprocessor EU responder: a fixed-depth PIPE adder and an ITER engine with operand-defined latency.
// Optional macro COPR_LATENCY_PERF_EN adds delivered-result and stall-cycle counters.
module copr_latency_engine #(
    parameter int XLEN        = 64,
    parameter int TAG_W       = 6,
    parameter int PIPE_DEPTH  = 4,
    parameter int MAX_LATENCY = 32,
    parameter int LAT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
`ifdef COPR_LATENCY_PERF_EN
    output logic [31:0] perf_done_cnt_o,
    output logic [31:0] perf_stall_cnt_o,
`endif
    copr_latency_engine_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    genvar gi;

    logic             pipe_v_reg   [PIPE_DEPTH];
    logic [TAG_W-1:0] pipe_tag_reg [PIPE_DEPTH];
    logic [XLEN-1:0]  pipe_data_reg[PIPE_DEPTH];

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0]  acc_reg;
    logic [TAG_W-1:0] iter_tag_reg;

    logic [TAG_W-1:0] hold_tag_reg;
    logic [XLEN-1:0]  hold_rd_reg;

    logic             pipe_empty;
    logic             last_v;
    logic             valid_out;
    logic [TAG_W-1:0] tag_out;
    logic [XLEN-1:0]  rd_out;
    logic             stall;
    logic             ready_out;
    logic             accept_pipe;
    logic             accept_iter;
    logic [LAT_W-1:0] lat_req;
    logic [CNT_W-1:0] lat_eff;

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (pipe_v_reg[i]) pipe_empty = 1'b0;
        end
    end

    assign last_v    = pipe_v_reg[PIPE_DEPTH-1];
    assign valid_out = last_v || (state_reg == ST_DONE);
    assign stall     = valid_out && !bus.ready_i;
    assign ready_out = !flush_i && !stall && (state_reg == ST_IDLE) && (!bus.ctl_i || pipe_empty);

    assign accept_pipe = bus.valid_i && ready_out && !bus.ctl_i;
    assign accept_iter = bus.valid_i && ready_out && bus.ctl_i;

    // A zero request still takes one cycle; oversize requests saturate before narrowing to the counter.
    always_comb begin
        lat_req = bus.rs2_i[LAT_W-1:0];
        if (lat_req == '0) begin
            lat_eff = CNT_W'(1);
        end else if (32'(lat_req) > 32'(MAX_LATENCY)) begin
            lat_eff = CNT_W'(MAX_LATENCY);
        end else begin
            lat_eff = CNT_W'(lat_req);
        end
    end

    // The whole pipe freezes on stall, so ops keep their spacing and leave in issue order.
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        pipe_v_reg[gi]    <= 1'b0;
                        pipe_tag_reg[gi]  <= '0;
                        pipe_data_reg[gi] <= '0;
                    end else if (flush_i) begin
                        pipe_v_reg[gi]    <= 1'b0;
                    end else if (!stall) begin
                        pipe_v_reg[gi]    <= accept_pipe;
                        if (accept_pipe) begin
                            pipe_tag_reg[gi]  <= bus.tag_i;
                            pipe_data_reg[gi] <= bus.rs1_i + bus.rs2_i;
                        end
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        pipe_v_reg[gi]    <= 1'b0;
                        pipe_tag_reg[gi]  <= '0;
                        pipe_data_reg[gi] <= '0;
                    end else if (flush_i) begin
                        pipe_v_reg[gi]    <= 1'b0;
                    end else if (!stall) begin
                        pipe_v_reg[gi]    <= pipe_v_reg[gi-1];
                        pipe_tag_reg[gi]  <= pipe_tag_reg[gi-1];
                        pipe_data_reg[gi] <= pipe_data_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            iter_tag_reg <= '0;
        end else if (flush_i) begin
            state_reg    <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept_iter) begin
                        iter_tag_reg <= bus.tag_i;
                        acc_reg      <= bus.rs1_i;
                        cnt_reg      <= lat_eff;
                        state_reg    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_reg <= acc_reg + {{(XLEN-1){1'b0}}, 1'b1};
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.ready_i) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // When nothing is valid the bus keeps showing the last presented tag/rd.
    always_comb begin
        if (last_v) begin
            tag_out = pipe_tag_reg[PIPE_DEPTH-1];
            rd_out  = pipe_data_reg[PIPE_DEPTH-1];
        end else if (state_reg == ST_DONE) begin
            tag_out = iter_tag_reg;
            rd_out  = acc_reg;
        end else begin
            tag_out = hold_tag_reg;
            rd_out  = hold_rd_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_tag_reg <= '0;
            hold_rd_reg  <= '0;
        end else begin
            hold_tag_reg <= tag_out;
            hold_rd_reg  <= rd_out;
        end
    end

    assign bus.ready_o = ready_out;
    assign bus.valid_o = valid_out;
    assign bus.tag_o   = tag_out;
    assign bus.rd_o    = rd_out;

`ifdef COPR_LATENCY_PERF_EN
    logic [31:0] perf_done_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_done_reg  <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (valid_out && bus.ready_i) perf_done_reg <= perf_done_reg + 32'd1;
            if (stall) perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_done_cnt_o  = perf_done_reg;
    assign perf_stall_cnt_o = perf_stall_reg;
`endif

endmodule

// File: tb/tb_copr_latency_engine.sv
// Self-checking bench for copr_latency_engine: directed scenarios plus a randomized run against a
// queue-based reference model of the issue/complete contract.
module tb_copr_latency_engine;
    localparam int XLEN        = 64;
    localparam int TAG_W       = 6;
    localparam int PIPE_DEPTH  = 4;
    localparam int MAX_LATENCY = 32;
    localparam int LAT_W       = 8;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic flush_i = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef COPR_LATENCY_PERF_EN
    logic [31:0] perf_done_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    copr_latency_engine_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    copr_latency_engine #(
        .XLEN(XLEN), .TAG_W(TAG_W), .PIPE_DEPTH(PIPE_DEPTH),
        .MAX_LATENCY(MAX_LATENCY), .LAT_W(LAT_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
`ifdef COPR_LATENCY_PERF_EN
        .perf_done_cnt_o (perf_done_cnt),
        .perf_stall_cnt_o(perf_stall_cnt),
`endif
        .bus             (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic c, input logic [TAG_W-1:0] t,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic rdy);
        bus.valid_i = v;
        bus.ctl_i   = c;
        bus.tag_i   = t;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        bus.ready_i = rdy;
    endtask

    function automatic int iter_lat(input logic [XLEN-1:0] rs2);
        int r;
        r = int'(rs2[LAT_W-1:0]);
        if (r == 0) return 1;
        if (r > MAX_LATENCY) return MAX_LATENCY;
        return r;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        #12;
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        n_checks++; if (bus.tag_o !== '0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", bus.tag_o); end
        n_checks++; if (bus.rd_o !== '0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", bus.rd_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_pipe: got %b want 1", bus.ready_o); end
        bus.ctl_i = 1'b1;
        #1;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_iter: got %b want 1", bus.ready_o); end
        bus.ctl_i = 1'b0;
        tick();
    endtask

    task automatic test_pipe_back_to_back();
        logic exp_v;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, TAG_W'(i + 1), 64'd10, 64'd5, 1);
            #1;
            n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready op%0d: got %b want 1", i, bus.ready_o); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 2; k < 8; k++) begin
            exp_v = (k >= 3 && k <= 5);
            n_checks++; if (bus.valid_o !== exp_v) begin n_fail++; $display("FAIL b2b_valid k=%0d: got %b want %b", k, bus.valid_o, exp_v); end
            if (exp_v) begin
                $display("b2b: tag=%0d rd=%0d", bus.tag_o, bus.rd_o);
                n_checks++; if (bus.tag_o !== TAG_W'(k - 2)) begin n_fail++; $display("FAIL b2b_tag k=%0d: got %0d want %0d", k, bus.tag_o, k - 2); end
                n_checks++; if (bus.rd_o !== 64'd15) begin n_fail++; $display("FAIL b2b_rd k=%0d: got %0d want 15", k, bus.rd_o); end
            end
            tick();
        end
    endtask

    task automatic test_iter_latency();
        logic [XLEN-1:0] vals [3];
        int lat;
        int k;
        vals = '{64'd7, 64'd0, 64'd200};
        for (int j = 0; j < 3; j++) begin
            lat = iter_lat(vals[j]);
            drive(1, 1, TAG_W'(20 + j), 64'd100, vals[j], 1);
            #1;
            n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL iter_ready rs2=%0d: got %b want 1", vals[j], bus.ready_o); end
            tick();
            drive(0, 0, 0, 0, 0, 1);
            k = 0;
            while (!bus.valid_o && k < 300) begin
                tick();
                k++;
            end
            $display("iter: rs2=%0d tag=%0d rd=%0d after %0d cycles", vals[j], bus.tag_o, bus.rd_o, k);
            n_checks++; if (k !== lat) begin n_fail++; $display("FAIL iter_latency rs2=%0d: got %0d want %0d", vals[j], k, lat); end
            n_checks++; if (bus.rd_o !== 64'(100 + lat)) begin n_fail++; $display("FAIL iter_rd rs2=%0d: got %0d want %0d", vals[j], bus.rd_o, 100 + lat); end
            n_checks++; if (bus.tag_o !== TAG_W'(20 + j)) begin n_fail++; $display("FAIL iter_tag: got %0d want %0d", bus.tag_o, 20 + j); end
            tick();
            n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL iter_drain: got %b want 0", bus.valid_o); end
        end
    endtask

    task automatic test_backpressure();
        drive(1, 0, 6'd5, 64'd1, 64'd2, 0);
        #1;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a: got %b want 1", bus.ready_o); end
        tick();
        drive(1, 0, 6'd6, 64'd3, 64'd4, 0);
        #1;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b: got %b want 1", bus.ready_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c=%0d: got %b want 1", c, bus.valid_o); end
            n_checks++; if (bus.tag_o !== 6'd5) begin n_fail++; $display("FAIL bp_hold_tag c=%0d: got %0d want 5", c, bus.tag_o); end
            n_checks++; if (bus.rd_o !== 64'd3) begin n_fail++; $display("FAIL bp_hold_rd c=%0d: got %0d want 3", c, bus.rd_o); end
            n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_stall c=%0d: got %b want 0", c, bus.ready_o); end
            tick();
        end
        bus.ready_i = 1'b1;
        #1;
        $display("bp: tag=%0d rd=%0d", bus.tag_o, bus.rd_o);
        n_checks++; if (bus.tag_o !== 6'd5 || bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_a: got v=%b tag=%0d want v=1 tag=5", bus.valid_o, bus.tag_o); end
        tick();
        $display("bp: tag=%0d rd=%0d", bus.tag_o, bus.rd_o);
        n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b want 1", bus.valid_o); end
        n_checks++; if (bus.tag_o !== 6'd6) begin n_fail++; $display("FAIL bp_second_tag: got %0d want 6", bus.tag_o); end
        n_checks++; if (bus.rd_o !== 64'd7) begin n_fail++; $display("FAIL bp_second_rd: got %0d want 7", bus.rd_o); end
        tick();
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_interlock();
        drive(1, 0, 6'd9, 64'd20, 64'd22, 1);
        tick();
        drive(1, 1, 6'd10, 64'd500, 64'd3, 1);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL lock_iter_wait k=%0d: got %b want 0", k, bus.ready_o); end
            if (k == 3) begin
                $display("lock: pipe tag=%0d rd=%0d", bus.tag_o, bus.rd_o);
                n_checks++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 64'd42) begin n_fail++; $display("FAIL lock_pipe_result: got v=%b rd=%0d want v=1 rd=42", bus.valid_o, bus.rd_o); end
            end
            tick();
        end
        #1;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL lock_iter_go: got %b want 1", bus.ready_o); end
        tick();
        drive(1, 0, 6'd11, 64'd1, 64'd1, 0);
        for (int j = 0; j < 5; j++) begin
            #1;
            n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL lock_pipe_wait j=%0d: got %b want 0", j, bus.ready_o); end
            if (j == 3) begin
                $display("lock: iter tag=%0d rd=%0d", bus.tag_o, bus.rd_o);
                n_checks++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 64'd503) begin n_fail++; $display("FAIL lock_iter_result: got v=%b rd=%0d want v=1 rd=503", bus.valid_o, bus.rd_o); end
            end
            tick();
        end
        bus.ready_i = 1'b1;
        #1;
        n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL lock_done_ready: got %b want 0", bus.ready_o); end
        tick();
        #1;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL lock_pipe_go: got %b want 1", bus.ready_o); end
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        tick();
        tick();
        $display("lock: pipe tag=%0d rd=%0d", bus.tag_o, bus.rd_o);
        n_checks++; if (bus.valid_o !== 1'b1 || bus.tag_o !== 6'd11 || bus.rd_o !== 64'd2) begin n_fail++; $display("FAIL lock_pipe_after: got v=%b tag=%0d rd=%0d want v=1 tag=11 rd=2", bus.valid_o, bus.tag_o, bus.rd_o); end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 1, 6'd12, 64'd7, 64'd10, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick(); tick(); tick();
        flush_i = 1'b1;
        drive(1, 0, 6'd13, 64'd1, 64'd1, 1);
        #1;
        n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus.ready_o); end
        tick();
        flush_i = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 15; c++) begin
            n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_iter_gone c=%0d: got %b want 0", c, bus.valid_o); end
            tick();
        end
        drive(1, 0, 6'd14, 64'd1, 64'd1, 1);
        tick();
        drive(1, 0, 6'd15, 64'd2, 64'd2, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_pipe_gone c=%0d: got %b want 0", c, bus.valid_o); end
            tick();
        end
        drive(1, 0, 6'd16, 64'd3, 64'd3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_pending_pre: got %b want 1", bus.valid_o); end
        flush_i = 1'b1;
        bus.ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_pending_drop c=%0d: got %b want 0", c, bus.valid_o); end
            tick();
        end
        drive(1, 0, 6'd17, 64'd40, 64'd2, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick(); tick(); tick();
        $display("flush: next tag=%0d rd=%0d", bus.tag_o, bus.rd_o);
        n_checks++; if (bus.valid_o !== 1'b1 || bus.tag_o !== 6'd17 || bus.rd_o !== 64'd42) begin n_fail++; $display("FAIL flush_next_op: got v=%b tag=%0d rd=%0d want v=1 tag=17 rd=42", bus.valid_o, bus.tag_o, bus.rd_o); end
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, 1, 6'd20, 64'd5, 64'd20, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        repeat (5) tick();
        #3;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_busy_valid: got %b want 0", bus.valid_o); end
        n_checks++; if (bus.tag_o !== '0) begin n_fail++; $display("FAIL areset_busy_tag: got %0d want 0", bus.tag_o); end
        n_checks++; if (bus.rd_o !== '0) begin n_fail++; $display("FAIL areset_busy_rd: got %0d want 0", bus.rd_o); end
        #2;
        rst_ni = 1'b1;
        tick();
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", bus.ready_o); end
        repeat (25) begin
            n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_no_partial: got %b want 0", bus.valid_o); end
            tick();
        end
        drive(1, 0, 6'd21, 64'd8, 64'd8, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL areset_pending_pre: got %b want 1", bus.valid_o); end
        #3;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.valid_o !== 1'b0 || bus.rd_o !== '0) begin n_fail++; $display("FAIL areset_pending: got v=%b rd=%0d want v=0 rd=0", bus.valid_o, bus.rd_o); end
        #2;
        rst_ni = 1'b1;
        bus.ready_i = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [TAG_W-1:0] q_tag [$];
        logic [XLEN-1:0]  q_rd  [$];
        int               q_lat [$];
        int               q_age [$];
        bit               q_iter[$];
        logic             pending;
        logic             exp_v, exp_r, stall_m, iter_busy, pipe_busy, acc;
        logic [XLEN-1:0]  a, b;
        int               lat;

        pending = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            exp_v = (q_tag.size() > 0) && (q_age[0] >= q_lat[0]);
            n_checks++; if (bus.valid_o !== exp_v) begin n_fail++; $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, bus.valid_o, exp_v); end
            if (exp_v) begin
                n_checks++; if (bus.tag_o !== q_tag[0]) begin n_fail++; $display("FAIL rand_tag cyc=%0d: got %0d want %0d", cyc, bus.tag_o, q_tag[0]); end
                n_checks++; if (bus.rd_o !== q_rd[0]) begin n_fail++; $display("FAIL rand_rd cyc=%0d: got %h want %h", cyc, bus.rd_o, q_rd[0]); end
            end

            if (!pending) begin
                a = {$urandom(), $urandom()};
                b = {$urandom(), $urandom()};
                b[7:0] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(33, 255)) : 8'($urandom_range(0, 40));
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, TAG_W'($urandom()), a, b, 1'b0);
            end
            bus.ready_i = $urandom_range(0, 3) != 0;
            flush_i     = $urandom_range(0, 49) == 0;
            #1;

            stall_m   = exp_v && !bus.ready_i;
            iter_busy = 1'b0;
            pipe_busy = 1'b0;
            foreach (q_iter[i]) begin
                if (q_iter[i]) iter_busy = 1'b1;
                else pipe_busy = 1'b1;
            end
            exp_r = !flush_i && !stall_m && !iter_busy && (!bus.ctl_i || !pipe_busy);
            n_checks++; if (bus.ready_o !== exp_r) begin n_fail++; $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, bus.ready_o, exp_r); end
            acc = bus.valid_i && exp_r;
            pending = bus.valid_i && !acc;

            if (flush_i) begin
                q_tag.delete(); q_rd.delete(); q_lat.delete(); q_age.delete(); q_iter.delete();
            end else if (!stall_m) begin
                if (exp_v && bus.ready_i) begin
                    $display("rand: delivered tag=%0d rd=%h", q_tag[0], q_rd[0]);
                    void'(q_tag.pop_front()); void'(q_rd.pop_front()); void'(q_lat.pop_front());
                    void'(q_age.pop_front()); void'(q_iter.pop_front());
                end
                foreach (q_age[i]) q_age[i]++;
                if (acc) begin
                    q_tag.push_back(bus.tag_i);
                    q_iter.push_back(bus.ctl_i);
                    q_age.push_back(0);
                    if (bus.ctl_i) begin
                        lat = iter_lat(bus.rs2_i);
                        q_lat.push_back(lat);
                        q_rd.push_back(bus.rs1_i + XLEN'(lat));
                    end else begin
                        q_lat.push_back(PIPE_DEPTH - 1);
                        q_rd.push_back(bus.rs1_i + bus.rs2_i);
                    end
                end
            end
            tick();
        end
        flush_i = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 1);
        test_reset();
        test_pipe_back_to_back();
        test_iter_latency();
        test_backpressure();
        test_interlock();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
